// File: rtl/mem_stage_pipe_pkg.sv
// Shared encodings for the EX/MEM pipeline register and its load formatter.
package mem_stage_pipe_pkg;

  // Load operation carried down the pipe with each entry.
  typedef enum logic [2:0] {
    MEMOPNOP = 3'd0,
    MEMOPLB  = 3'd1,
    MEMOPLBU = 3'd2,
    MEMOPLH  = 3'd3,
    MEMOPLHU = 3'd4,
    MEMOPLW  = 3'd5,
    MEMOPLWU = 3'd6,
    MEMOPLD  = 3'd7
  } mem_op_e;

  // Exception and ctrl-op codes; cast to the instance widths at the use site.
  localparam int ISAEXP_NOEXP    = 0;
  localparam int ISAEXP_MISALIGN = 3;
  localparam int CTRLOPNOP       = 0;

  // Width-independent part of a stage payload.
  typedef struct packed {
    logic    en;
    logic    br_flag;
    logic    gpr_we_;
    mem_op_e mem_op;
  } stage_ctrl_t;

  localparam stage_ctrl_t BUBBLE_CTRL = '{en: 1'b0, br_flag: 1'b0, gpr_we_: 1'b1, mem_op: MEMOPNOP};

  // Byte-offset width inside one data word: 2 for 32-bit, 3 for 64-bit.
  function automatic int offset_width(int dw);
    return (dw == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/mem_stage_pipe_load_fmt.sv
// Load-data formatter: selects the byte/half/word/dword addressed by the
// stored offset and sign- or zero-extends it to DW. NOP passes the ALU result.
module load_fmt
  import mem_stage_pipe_pkg::*;
#(
  parameter int DW   = 32,
  parameter int OFFW = offset_width(DW)
) (
  input  mem_op_e         mem_op,
  input  logic [OFFW-1:0] offset,
  input  logic [DW-1:0]   rd_data,
  input  logic [DW-1:0]   data,
  output logic [DW-1:0]   result
);

  logic [OFFW-1:0] off_h;
  logic [OFFW-1:0] off_w;
  logic [7:0]      byte_f;
  logic [15:0]     half_f;
  logic [31:0]     word_f;

  // Naturally-aligned field extraction, then extension per op.
  always_comb begin
    off_h      = offset;
    off_h[0]   = 1'b0;
    off_w      = offset;
    off_w[1:0] = 2'b00;
    byte_f     = rd_data[{offset, 3'b000} +: 8];
    half_f     = rd_data[{off_h, 3'b000} +: 16];
    word_f     = rd_data[{off_w, 3'b000} +: 32];
    result     = data;
    case (mem_op)
      MEMOPLB:  result = DW'($signed(byte_f));
      MEMOPLBU: result = DW'(byte_f);
      MEMOPLH:  result = DW'($signed(half_f));
      MEMOPLHU: result = DW'(half_f);
      MEMOPLW:  result = DW'($signed(word_f));
      MEMOPLWU: result = DW'(word_f);
      // On a 32-bit datapath the whole word is the aligned word, so this
      // also covers LD-as-LW there.
      MEMOPLD:  result = rd_data;
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// EX/MEM pipeline register, RD_LAT deep to match data-memory read latency,
// with the load formatter on the last stage.
// Optional: define MISALIGN_EXP_EN to raise ISAEXP_MISALIGN on misaligned
// LH/LW/LWU/LD at EX capture instead of silently truncating the offset.
module mem_stage_pipe
  import mem_stage_pipe_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RD_LAT = 2,
  parameter int EXPW   = 3,
  parameter int CTRLW  = 2,
  parameter int RAW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_en,
  input  logic [DW-1:0]    ex_pc,
  input  logic             ex_br_flag,
  input  logic [CTRLW-1:0] ex_ctrl_op,
  input  logic [RAW-1:0]   ex_dst_addr,
  input  logic             ex_gpr_we_,
  input  logic [EXPW-1:0]  ex_exp_code,
  input  logic [2:0]       ex_mem_op,
  input  logic [DW-1:0]    ex_out,
  input  logic [DW-1:0]    rd_data,
  output logic             mem_en,
  output logic [DW-1:0]    mem_pc,
  output logic             mem_br_flag,
  output logic [CTRLW-1:0] mem_ctrl_op,
  output logic [RAW-1:0]   mem_dst_addr,
  output logic             mem_gpr_we_,
  output logic [EXPW-1:0]  mem_exp_code,
  output logic [DW-1:0]    mem_out,
  output logic [2:0]       ld_inflight
);

  localparam int OFFW = offset_width(DW);
  localparam int LAST = RD_LAT - 1;

  stage_ctrl_t      ctrl_q [RD_LAT];
  stage_ctrl_t      ctrl_d [RD_LAT];
  logic [DW-1:0]    pc_q   [RD_LAT];
  logic [DW-1:0]    pc_d   [RD_LAT];
  logic [CTRLW-1:0] cop_q  [RD_LAT];
  logic [CTRLW-1:0] cop_d  [RD_LAT];
  logic [RAW-1:0]   dst_q  [RD_LAT];
  logic [RAW-1:0]   dst_d  [RD_LAT];
  logic [EXPW-1:0]  exp_q  [RD_LAT];
  logic [EXPW-1:0]  exp_d  [RD_LAT];
  logic [DW-1:0]    data_q [RD_LAT];
  logic [DW-1:0]    data_d [RD_LAT];
  logic [OFFW-1:0]  off_q  [RD_LAT];
  logic [OFFW-1:0]  off_d  [RD_LAT];
  logic [2:0]       ld_inflight_q;
  logic [2:0]       ld_inflight_d;

  stage_ctrl_t      cap_ctrl;
  logic [EXPW-1:0]  cap_exp;
  logic [DW-1:0]    cap_data;
  logic [DW-1:0]    fmt_result;
`ifdef MISALIGN_EXP_EN
  logic             misalign;
`endif

  // Build the stage-0 payload from EX, turning misaligned loads into
  // exception bubbles when that check is enabled.
  always_comb begin
    cap_ctrl.en      = ex_en;
    cap_ctrl.br_flag = ex_br_flag;
    cap_ctrl.gpr_we_ = ex_gpr_we_;
    cap_ctrl.mem_op  = mem_op_e'(ex_mem_op);
    cap_exp          = ex_exp_code;
    cap_data         = ex_out;
`ifdef MISALIGN_EXP_EN
    case (mem_op_e'(ex_mem_op))
      MEMOPLH:           misalign = ex_out[0];
      MEMOPLW, MEMOPLWU: misalign = |ex_out[1:0];
      MEMOPLD:           misalign = |ex_out[OFFW-1:0];
      default:           misalign = 1'b0;
    endcase
    if (misalign && (ex_exp_code == EXPW'(ISAEXP_NOEXP))) begin
      cap_exp          = EXPW'(ISAEXP_MISALIGN);
      cap_ctrl.gpr_we_ = 1'b1;
      cap_ctrl.mem_op  = MEMOPNOP;
      cap_data         = '0;
    end
`endif
  end

  // Next state: hold on stall, bubble everything on flush, else shift.
  // The load count is taken over the post-edge contents.
  always_comb begin
    ctrl_d = ctrl_q;
    pc_d   = pc_q;
    cop_d  = cop_q;
    dst_d  = dst_q;
    exp_d  = exp_q;
    data_d = data_q;
    off_d  = off_q;
    if (!stall) begin
      if (flush) begin
        for (int i = 0; i < RD_LAT; i++) begin
          ctrl_d[i] = BUBBLE_CTRL;
          pc_d[i]   = '0;
          cop_d[i]  = CTRLW'(CTRLOPNOP);
          dst_d[i]  = '0;
          exp_d[i]  = EXPW'(ISAEXP_NOEXP);
          data_d[i] = '0;
          off_d[i]  = '1;
        end
      end else begin
        ctrl_d[0] = cap_ctrl;
        pc_d[0]   = ex_pc;
        cop_d[0]  = ex_ctrl_op;
        dst_d[0]  = ex_dst_addr;
        exp_d[0]  = cap_exp;
        data_d[0] = cap_data;
        off_d[0]  = ex_out[OFFW-1:0];
        for (int i = 1; i < RD_LAT; i++) begin
          ctrl_d[i] = ctrl_q[i-1];
          pc_d[i]   = pc_q[i-1];
          cop_d[i]  = cop_q[i-1];
          dst_d[i]  = dst_q[i-1];
          exp_d[i]  = exp_q[i-1];
          data_d[i] = data_q[i-1];
          off_d[i]  = off_q[i-1];
        end
      end
    end
    ld_inflight_d = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (ctrl_d[i].en && (ctrl_d[i].mem_op != MEMOPNOP)) begin
        ld_inflight_d = ld_inflight_d + 3'd1;
      end
    end
  end

  // Stage registers; async reset fills every stage with a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        ctrl_q[i] <= BUBBLE_CTRL;
        pc_q[i]   <= '0;
        cop_q[i]  <= CTRLW'(CTRLOPNOP);
        dst_q[i]  <= '0;
        exp_q[i]  <= EXPW'(ISAEXP_NOEXP);
        data_q[i] <= '0;
        off_q[i]  <= '1;
      end
      ld_inflight_q <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      pc_q          <= pc_d;
      cop_q         <= cop_d;
      dst_q         <= dst_d;
      exp_q         <= exp_d;
      data_q        <= data_d;
      off_q         <= off_d;
      ld_inflight_q <= ld_inflight_d;
    end
  end

  load_fmt #(.DW(DW), .OFFW(OFFW)) u_load_fmt (
    .mem_op  (ctrl_q[LAST].mem_op),
    .offset  (off_q[LAST]),
    .rd_data (rd_data),
    .data    (data_q[LAST]),
    .result  (fmt_result)
  );

  // Result is zero for a bubble and while a flush is taking effect.
  always_comb begin
    mem_out = '0;
    if (ctrl_q[LAST].en && !(flush && !stall)) begin
      mem_out = fmt_result;
    end
  end

  assign mem_en       = ctrl_q[LAST].en;
  assign mem_pc       = pc_q[LAST];
  assign mem_br_flag  = ctrl_q[LAST].br_flag;
  assign mem_ctrl_op  = cop_q[LAST];
  assign mem_dst_addr = dst_q[LAST];
  assign mem_gpr_we_  = ctrl_q[LAST].gpr_we_;
  assign mem_exp_code = exp_q[LAST];
  assign ld_inflight  = ld_inflight_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: a 32-bit/RD_LAT=2 and a 64-bit/RD_LAT=3 instance
// share clock, reset, stall and flush. Accepted EX entries are logged in a
// history; the output is the entry RD_LAT accepted cycles back.
module tb_mem_stage_pipe;
  import mem_stage_pipe_pkg::*;

  typedef struct {
    logic        en;
    logic [63:0] pc;
    logic        br;
    logic [1:0]  ctrl;
    logic [4:0]  dst;
    logic        we_;
    logic [2:0]  exp;
    logic [2:0]  op;
    logic [63:0] data;
    logic [63:0] addr;
    logic [63:0] rd;
  } ent_t;

  logic clk = 1'b0;
  logic reset, stall, flush;

  logic        en_i   [2];
  logic        br_i   [2];
  logic [1:0]  ctrl_i [2];
  logic [4:0]  dst_i  [2];
  logic        we_i   [2];
  logic [2:0]  exp_i  [2];
  logic [2:0]  op_i   [2];
  logic [63:0] rdv_i  [2];
  logic [31:0] pc0, exo0, rd0;
  logic [63:0] pc1, exo1, rd1;

  logic        o_en   [2];
  logic        o_br   [2];
  logic [1:0]  o_ctrl [2];
  logic [4:0]  o_dst  [2];
  logic        o_we   [2];
  logic [2:0]  o_exp  [2];
  logic [2:0]  o_infl [2];
  logic [31:0] mpc0, mo0;
  logic [63:0] mpc1, mo1;

  ent_t hist [2][1024];
  int   n [2] = '{2, 3};
  int   ncmp = 0;
  int   nbad = 0;
  int   pcs  = 0;

  always #5 clk = ~clk;

  mem_stage_pipe #(.DW(32), .RD_LAT(2)) u32 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_en(en_i[0]), .ex_pc(pc0), .ex_br_flag(br_i[0]), .ex_ctrl_op(ctrl_i[0]),
    .ex_dst_addr(dst_i[0]), .ex_gpr_we_(we_i[0]), .ex_exp_code(exp_i[0]),
    .ex_mem_op(op_i[0]), .ex_out(exo0), .rd_data(rd0),
    .mem_en(o_en[0]), .mem_pc(mpc0), .mem_br_flag(o_br[0]), .mem_ctrl_op(o_ctrl[0]),
    .mem_dst_addr(o_dst[0]), .mem_gpr_we_(o_we[0]), .mem_exp_code(o_exp[0]),
    .mem_out(mo0), .ld_inflight(o_infl[0])
  );

  mem_stage_pipe #(.DW(64), .RD_LAT(3)) u64 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_en(en_i[1]), .ex_pc(pc1), .ex_br_flag(br_i[1]), .ex_ctrl_op(ctrl_i[1]),
    .ex_dst_addr(dst_i[1]), .ex_gpr_we_(we_i[1]), .ex_exp_code(exp_i[1]),
    .ex_mem_op(op_i[1]), .ex_out(exo1), .rd_data(rd1),
    .mem_en(o_en[1]), .mem_pc(mpc1), .mem_br_flag(o_br[1]), .mem_ctrl_op(o_ctrl[1]),
    .mem_dst_addr(o_dst[1]), .mem_gpr_we_(o_we[1]), .mem_exp_code(o_exp[1]),
    .mem_out(mo1), .ld_inflight(o_infl[1])
  );

  function automatic int lat(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int dwid(int k);
    return (k == 0) ? 32 : 64;
  endfunction

  function automatic ent_t bubble();
    ent_t b;
    b.en = 1'b0; b.pc = '0; b.br = 1'b0; b.ctrl = '0; b.dst = '0; b.we_ = 1'b1;
    b.exp = 3'(ISAEXP_NOEXP); b.op = MEMOPNOP; b.data = '0; b.addr = '0; b.rd = '0;
    return b;
  endfunction

  // Arithmetic description of the formatted result.
  function automatic logic [63:0] fmt(int dw, logic [2:0] op, logic [63:0] a,
                                      logic [63:0] d, logic [63:0] rd);
    int nb, off, sz;
    bit sg;
    logic [63:0] m, f, dm;
    dm = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    nb = dw / 8;
    off = int'(a[5:0]) % nb;
    case (op)
      MEMOPLB:  begin sz = 1; sg = 1; end
      MEMOPLBU: begin sz = 1; sg = 0; end
      MEMOPLH:  begin sz = 2; sg = 1; end
      MEMOPLHU: begin sz = 2; sg = 0; end
      MEMOPLW:  begin sz = 4; sg = 1; end
      MEMOPLWU: begin sz = 4; sg = 0; end
      MEMOPLD:  begin sz = 8; sg = 0; end
      default:  return d & dm;
    endcase
    if (sz > nb) begin sz = nb; sg = 1; end
    off = off - (off % sz);
    f = rd >> (8 * off);
    if (sz < 8) begin
      m = (64'd1 << (8 * sz)) - 64'd1;
      f = f & m;
      if (sg && f[8*sz-1]) f = f | ~m;
    end
    return f & dm;
  endfunction

`ifdef MISALIGN_EXP_EN
  function automatic bit misal(int dw, logic [2:0] op, logic [63:0] a);
    int off;
    off = int'(a[5:0]) % (dw / 8);
    if (op == MEMOPLH) return (off % 2) != 0;
    if (op == MEMOPLW || op == MEMOPLWU) return (off % 4) != 0;
    if (op == MEMOPLD) return (off % 8) != 0;
    return 1'b0;
  endfunction
`endif

  function automatic ent_t capture(int k);
    ent_t e;
    e.en = en_i[k]; e.br = br_i[k]; e.ctrl = ctrl_i[k]; e.dst = dst_i[k];
    e.we_ = we_i[k]; e.exp = exp_i[k]; e.op = op_i[k]; e.rd = rdv_i[k];
    e.pc   = (k == 0) ? {32'b0, pc0} : pc1;
    e.data = (k == 0) ? {32'b0, exo0} : exo1;
    e.addr = e.data;
`ifdef MISALIGN_EXP_EN
    if (misal(dwid(k), e.op, e.addr) && e.exp == 3'(ISAEXP_NOEXP)) begin
      e.exp = 3'(ISAEXP_MISALIGN); e.we_ = 1'b1; e.op = MEMOPNOP; e.data = '0;
    end
`endif
    return e;
  endfunction

  // History model: accepted entries appended, flush/reset blank the window.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < lat(k); j++) hist[k][n[k]-1-j] = bubble();
    end else if (!stall) begin
      for (int k = 0; k < 2; k++) begin
        hist[k][n[k]] = flush ? bubble() : capture(k);
        n[k]++;
        if (flush)
          for (int j = 0; j < lat(k); j++) hist[k][n[k]-1-j] = bubble();
      end
    end
    rd0 = hist[0][n[0]-2].rd[31:0];
    rd1 = hist[1][n[1]-3].rd;
  end

  task automatic chk(string nm, int k, logic [63:0] got, logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s inst%0d got=%h expected=%h at %0t", nm, k, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] got_out(int k);
    return (k == 0) ? {32'b0, mo0} : mo1;
  endfunction

  // Per-cycle comparison of every output against the history model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ent_t e;
      int cnt;
      logic [63:0] eo;
      e = hist[k][n[k]-lat(k)];
      cnt = 0;
      for (int j = 1; j <= lat(k); j++)
        if (hist[k][n[k]-j].en && hist[k][n[k]-j].op != MEMOPNOP) cnt++;
      eo = (flush && !stall) ? 64'd0 : (e.en ? fmt(dwid(k), e.op, e.addr, e.data, e.rd) : 64'd0);
      chk("mem_en", k, 64'(o_en[k]), 64'(e.en));
      chk("mem_pc", k, (k == 0) ? {32'b0, mpc0} : mpc1, e.pc);
      chk("mem_br", k, 64'(o_br[k]), 64'(e.br));
      chk("mem_ctrl", k, 64'(o_ctrl[k]), 64'(e.ctrl));
      chk("mem_dst", k, 64'(o_dst[k]), 64'(e.dst));
      chk("mem_we_", k, 64'(o_we[k]), 64'(e.we_));
      chk("mem_exp", k, 64'(o_exp[k]), 64'(e.exp));
      chk("mem_out", k, got_out(k), eo);
      chk("ld_inflight", k, 64'(o_infl[k]), 64'(cnt));
    end
  end

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      en_i[k] = 1'b0; br_i[k] = 1'b0; ctrl_i[k] = '0; dst_i[k] = '0; we_i[k] = 1'b1;
      exp_i[k] = '0; op_i[k] = MEMOPNOP; rdv_i[k] = '0;
    end
    pc0 = '0; exo0 = '0; pc1 = '0; exo1 = '0;
  endtask

  task automatic set_in(int k, logic [2:0] op, logic [63:0] addr, logic [63:0] rdv,
                        logic [2:0] ex);
    pcs++;
    en_i[k] = 1'b1; op_i[k] = op; rdv_i[k] = rdv; exp_i[k] = ex; we_i[k] = 1'b0;
    br_i[k] = pcs[0]; ctrl_i[k] = pcs[2:1]; dst_i[k] = addr[4:0] ^ 5'h11;
    if (k == 0) begin pc0 = 32'h400 + 32'(pcs * 4); exo0 = addr[31:0]; end
    else begin pc1 = 64'hF000_0000_0000_0400 + 64'(pcs * 4); exo1 = addr; end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_one(int k, logic [2:0] op, logic [63:0] addr, logic [63:0] rdv,
                         logic [2:0] ex, logic [63:0] exp_out, string nm);
    set_in(k, op, addr, rdv, ex);
    tick();
    idle();
    repeat (lat(k) - 1) tick();
    chk(nm, k, got_out(k), exp_out);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_en", k, 64'(o_en[k]), 64'd0);
      chk("rst_we_", k, 64'(o_we[k]), 64'd1);
      chk("rst_out", k, got_out(k), 64'd0);
      chk("rst_infl", k, 64'(o_infl[k]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 32-bit byte/half/word formatting
    run_one(0, MEMOPLB,  'h1003, 'h80FF_1234, 3'd0, 64'hFFFF_FF80, "lit_lb");
    run_one(0, MEMOPLBU, 'h1003, 'h80FF_1234, 3'd2, 64'h0000_0080, "lit_lbu");
    run_one(0, MEMOPLH,  'h2002, 'h8001_7FFF, 3'd0, 64'hFFFF_8001, "lit_lh");
    run_one(0, MEMOPLHU, 'h2000, 'h8001_7FFF, 3'd0, 64'h0000_7FFF, "lit_lhu");
    run_one(0, MEMOPLW,  'h2000, 'h1234_5678, 3'd0, 64'h1234_5678, "lit_lw32");
    run_one(0, MEMOPNOP, 'hDEAD_BEEF, 'h0, 3'd0, 64'hDEAD_BEEF, "lit_nop");

    // 64-bit word/dword/byte formatting
    run_one(1, MEMOPLW,  'h4004, 'h8000_0000_0000_0001, 3'd0, 64'hFFFF_FFFF_8000_0000, "lit_lw64");
    run_one(1, MEMOPLWU, 'h4004, 'h8000_0000_0000_0001, 3'd0, 64'h0000_0000_8000_0000, "lit_lwu64");
    run_one(1, MEMOPLD,  'h4000, 'h8000_0000_0000_0001, 3'd0, 64'h8000_0000_0000_0001, "lit_ld");
    run_one(1, MEMOPLB,  'h4007, 'h7F00_0000_0000_0000, 3'd0, 64'h0000_0000_0000_007F, "lit_lb64");
    run_one(1, MEMOPLH,  'h4006, 'hFFFE_0000_0000_0000, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, "lit_lh64");

    // Misaligned word load
`ifdef MISALIGN_EXP_EN
    run_one(0, MEMOPLW, 'h3002, 'hAABB_CCDD, 3'd0, 64'd0, "lit_mis_out");
    chk("lit_mis_exp", 0, 64'(o_exp[0]), 64'(ISAEXP_MISALIGN));
    chk("lit_mis_we_", 0, 64'(o_we[0]), 64'd1);
`else
    run_one(0, MEMOPLW, 'h3002, 'hAABB_CCDD, 3'd0, 64'hAABB_CCDD, "lit_mis_out");
    chk("lit_mis_exp", 0, 64'(o_exp[0]), 64'(ISAEXP_NOEXP));
    chk("lit_mis_we_", 0, 64'(o_we[0]), 64'd0);
`endif

    // Back-to-back loads with a two-cycle stall
    set_in(1, MEMOPLD, 'h100, 'hA1, 3'd0); tick();
    chk("st_infl1", 1, 64'(o_infl[1]), 64'd1);
    set_in(1, MEMOPLD, 'h108, 'hA2, 3'd0); tick();
    chk("st_infl2", 1, 64'(o_infl[1]), 64'd2);
    set_in(1, MEMOPLD, 'h110, 'hA3, 3'd0); tick();
    chk("st_infl3", 1, 64'(o_infl[1]), 64'd3);
    chk("st_out1", 1, got_out(1), 64'hA1);
    stall = 1'b1;
    set_in(1, MEMOPLD, 'h118, 'hA9, 3'd0);
    tick();
    chk("st_hold_infl", 1, 64'(o_infl[1]), 64'd3);
    chk("st_hold_out", 1, got_out(1), 64'hA1);
    idle();
    tick();
    chk("st_hold_infl2", 1, 64'(o_infl[1]), 64'd3);
    chk("st_hold_out2", 1, got_out(1), 64'hA1);
    stall = 1'b0;
    tick();
    chk("st_out2", 1, got_out(1), 64'hA2);
    chk("st_infl_dn2", 1, 64'(o_infl[1]), 64'd2);
    tick();
    chk("st_out3", 1, got_out(1), 64'hA3);
    chk("st_infl_dn1", 1, 64'(o_infl[1]), 64'd1);
    tick();
    chk("st_infl_dn0", 1, 64'(o_infl[1]), 64'd0);

    // Flush with two loads in flight, first masked by stall
    set_in(1, MEMOPLD, 'h200, 'hB1, 3'd0); tick();
    set_in(1, MEMOPLD, 'h208, 'hB2, 3'd0); tick();
    idle();
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("fl_stall_infl", 1, 64'(o_infl[1]), 64'd2);
    stall = 1'b0;
    set_in(1, MEMOPLD, 'h210, 'hB3, 3'd0);
    tick();
    chk("fl_en", 1, 64'(o_en[1]), 64'd0);
    chk("fl_we_", 1, 64'(o_we[1]), 64'd1);
    chk("fl_infl", 1, 64'(o_infl[1]), 64'd0);
    flush = 1'b0;
    idle();
    repeat (4) tick();

    // Combinational zeroing of mem_out during flush
    run_one(0, MEMOPNOP, 'h55, 'h0, 3'd0, 64'h55, "lit_pre_flush");
    flush = 1'b1;
    #1;
    chk("fl_out_forced", 0, got_out(0), 64'd0);
    tick();
    flush = 1'b0;
    tick();

    // Asynchronous reset mid-stream
    set_in(1, MEMOPLD, 'h300, 'hC1, 3'd0);
    set_in(0, MEMOPLB, 'h301, 'hC2C2, 3'd0);
    tick();
    idle();
    tick();
    chk("pre_rst_infl", 1, 64'(o_infl[1]), 64'd1);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_en", k, 64'(o_en[k]), 64'd0);
      chk("arst_we_", k, 64'(o_we[k]), 64'd1);
      chk("arst_out", k, got_out(k), 64'd0);
      chk("arst_infl", k, 64'(o_infl[k]), 64'd0);
    end
    reset = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
Parametrised EX/MEM pipeline register with an integrated load-data formatter. Carries EX-stage control/result through a RD_LAT-deep pipe matched to the data-memory read latency, so mem_* control and formatted mem_out emerge in the same cycle. Supports 32/64-bit data and full byte/half/word(/dword) sign/zero extension. Sits between the EX stage and the WB/forwarding logic.

Parameters:
DW, 32, data/address width; 32 or 64 only
RD_LAT, 2, data-memory read latency in cycles and pipe depth; 1..4
EXPW, 3, exception code width
CTRLW, 2, ctrl op width
RAW, 5, register address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
stall  in  1  hold all stages
flush  in  1  insert bubbles into all stages
ex_en  in  1  EX entry valid
ex_pc  in  DW  EX pc
ex_br_flag  in  1  branch-slot flag
ex_ctrl_op  in  CTRLW  ctrl op
ex_dst_addr  in  RAW  destination GPR
ex_gpr_we_  in  1  GPR write enable, active-low
ex_exp_code  in  EXPW  exception code
ex_mem_op  in  3  load op (NOP,LB,LBU,LH,LHU,LW,LWU,LD)
ex_out  in  DW  ALU result; load address for loads
rd_data  in  DW  memory read data, valid RD_LAT cycles after address
mem_en  out  1  stage valid
mem_pc  out  DW  pc
mem_br_flag  out  1  branch-slot flag
mem_ctrl_op  out  CTRLW  ctrl op
mem_dst_addr  out  RAW  destination GPR
mem_gpr_we_  out  1  GPR write enable, active-low
mem_exp_code  out  EXPW  exception code
mem_out  out  DW  formatted result (combinational from last stage + rd_data)
ld_inflight  out  3  count of valid load entries in pipe, 0..RD_LAT

Behaviour:
- Pipe: RD_LAT stages; each holds en, pc, br_flag, ctrl_op, dst_addr, gpr_we_, exp_code, mem_op, ex_out, offset = ex_out[log2(DW/8)-1:0]. mem_* outputs = last stage.
- Reset (async, reset=0): every stage bubble: en=0, pc=0, br_flag=0, ctrl_op=NOP, dst_addr=0, gpr_we_=1, exp_code=NOEXP, mem_op=NOP, data=0, offset=all-ones; mem_out=0; ld_inflight=0.
- Latency: an EX entry appears on mem_* exactly RD_LAT unstalled cycles later.
- stall=1: all stages hold; flush ignored (stall wins). Memory holds rd_data while stalled.
- stall=0, flush=1: all stages load the bubble value in one edge; mem_out forced 0 combinationally while flush=1.
- ld_inflight: registered count of stages with en=1 and mem_op!=NOP; updated on same edge; 0 after flush/reset.
- mem_out, last-stage mem_op: NOP -> stored ex_out. LB/LBU -> byte at rd_data[8*off +: 8], sign/zero-extended to DW. LH/LHU -> half at 16*off[..:1]. LW/LWU -> word at 32*off[..:2]; LW sign-extends when DW=64, equals word when DW=32. LD (DW=64 only) -> rd_data. LWU/LD with DW=32 treated as LW.
- Sign extension replicates the field MSB across all upper bits (correct two's complement).
- Bubble in last stage (en=0): mem_out = 0.

Optional Feature:
MISALIGN_EXP_EN: when defined, LH with off[0]!=0, LW/LWU with off[1:0]!=0, LD with off[2:0]!=0 is flagged at EX capture: if ex_exp_code==NOEXP, stage exp_code=ISAEXP_MISALIGN, gpr_we_=1, mem_op=NOP, data=0. Without it, low offset bits below the access size are ignored (naturally-aligned truncation), no exception.

Decomposition:
- Package: mem-op encodings (MEMOPNOP..MEMOPLD), ISAEXP_NOEXP, ISAEXP_MISALIGN, CTRLOPNOP, stage-payload struct/width constants.
- Sub-module: load_fmt (combinational: mem_op, offset, rd_data -> formatted DW result), instanced once on the last stage.

Test Plan:
- DW=32, RD_LAT=2: LB addr 0x1003, rd_data 0x80FF_1234 -> mem_out 0xFFFF_FF80 two cycles after EX; LBU -> 0x0000_0080.
- LH addr 0x2002, rd_data 0x8001_7FFF -> 0xFFFF_8001; LHU addr 0x2000 -> 0x0000_7FFF.
- DW=64, RD_LAT=3: LW addr offset 4, rd_data 0x8000_0000_0000_0001 -> 0xFFFF_FFFF_8000_0000; LWU -> 0x0000_0000_8000_0000; LD -> rd_data.
- Back-to-back 3 loads, stall=1 for 2 cycles mid-stream -> outputs held, order preserved, ld_inflight steps 1,2,3 then holds 3 while stalled.
- flush=1 with 2 loads in flight -> next edge mem_en=0, mem_gpr_we_=1, ld_inflight=0; flush with stall=1 -> no change.
- MISALIGN_EXP_EN: LW addr 0x3002 -> mem_exp_code=ISAEXP_MISALIGN, mem_gpr_we_=1, mem_out=0; reset asserted mid-stream -> all outputs to reset values immediately.
